tc_insn_fetch8: RTL and testbench
=================================

TC_INSN_FETCH8 -- requirements
Module: tc_insn_fetch8

Interface
REQ-001 SHALL have parameter INSN_BYTES, default 4, bytes per instruction, legal range 1..4.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_addr  output  16  byte address to the program memory.
REQ-006 SHALL have port mem_data  input  8  byte returned by the program memory, registered, one cycle after mem_addr.
REQ-007 SHALL have port jump_en  input  1  redirect request.
REQ-008 SHALL have port jump_target  input  16  redirect address, sampled when jump_en=1.
REQ-009 SHALL have port insn  output  32  assembled instruction, little-endian, unused upper bytes zero.
REQ-010 SHALL have port insn_pc  output  16  address of byte 0 of insn.
REQ-011 SHALL have port insn_valid  output  1  insn/insn_pc hold a complete instruction.
REQ-012 SHALL have port insn_ready  input  1  consumer accepts insn this cycle.

Function
REQ-013 SHALL implement two states: FETCH (byte index k=0..INSN_BYTES) and HOLD.
REQ-014 In FETCH, SHALL drive mem_addr = pc + k (mod 2^16) for k<INSN_BYTES; at k=INSN_BYTES, mem_addr = pc.
REQ-015 In FETCH with k>=1, SHALL capture mem_data into insn byte k-1 at the clock edge.
REQ-016 SHALL move FETCH->HOLD after capturing byte INSN_BYTES-1; insn_valid rises INSN_BYTES+1 cycles after FETCH entry with k=0.
REQ-017 In HOLD, insn, insn_pc, insn_valid SHALL stay stable until insn_valid && insn_ready.
REQ-018 On transfer, SHALL set pc = pc + INSN_BYTES (mod 2^16), clear insn_valid, enter FETCH with k=0 on the next cycle.
REQ-019 In HOLD, mem_addr SHALL equal insn_pc.
REQ-020 On jump_en=1 in any state, SHALL set pc = jump_target, clear insn_valid, discard partial bytes and any in-flight mem_data, and enter FETCH with k=0.
REQ-021 When jump_en and a transfer occur in the same cycle, the transfer SHALL complete and the next fetch SHALL start at jump_target.
REQ-022 An instruction straddling 16'hFFFF SHALL wrap to 16'h0000 for the following bytes; insn_pc keeps the original address.

Reset
REQ-023 While rst=0, SHALL force state FETCH, k=0, pc=RESET_PC, insn=0, insn_pc=0, insn_valid=0.
REQ-024 In the first cycle after rst rises, mem_addr SHALL equal RESET_PC.
REQ-025 Assertion of rst mid-fetch or in HOLD SHALL abort immediately with no instruction delivered.

Configuration
REQ-026 With TC_INSN_FETCH_PERF_EN defined, SHALL add outputs stall_cycles[31:0], the count of cycles with insn_valid && !insn_ready, and insn_count[31:0], the count of transfers; both saturate at 32'hFFFFFFFF and reset to 0.
REQ-027 Without TC_INSN_FETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package tc_fetch_pkg SHALL hold the state enum, ADDR_W=16, BYTE_W=8, INSN_W=32, INSN_BYTES_MAX=4.
REQ-029 Counters SHALL live in sub-module tc_fetch_perf_ctr, instantiated only under TC_INSN_FETCH_PERF_EN.

Verification
REQ-030 SHALL cover reset release with mem bytes 0x00:11,0x01:22,0x02:33,0x03:44 and ready=1 -> insn=32'h44332211, insn_pc=0, valid on cycle 5, next insn_pc=4.
REQ-031 SHALL cover ready=0 for 10 cycles after valid -> insn stable for the whole window; stall_cycles=10 with PERF_EN defined.
REQ-032 SHALL cover jump_en with jump_target=16'h0100 at k=2 -> partial bytes discarded; next valid insn_pc=16'h0100 with bytes from 0x100..0x103.
REQ-033 SHALL cover a fetch at pc=16'hFFFE -> bytes from FFFE,FFFF,0000,0001; insn_pc=16'hFFFE; next pc=16'h0002.
REQ-034 SHALL cover jump_en together with a transfer -> insn_count +1 and next fetch at jump_target.
REQ-035 SHALL cover INSN_BYTES=1 and rst asserted in HOLD -> valid on cycle 2, insn[31:8]=0; after reset, valid=0 and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/tc_fetch_pkg.sv
// Shared types and widths for the byte-serial instruction fetch unit.
package tc_fetch_pkg;

  localparam int ADDR_W         = 16;
  localparam int BYTE_W         = 8;
  localparam int INSN_W         = 32;
  localparam int INSN_BYTES_MAX = 4;
  // Byte index k spans 0..INSN_BYTES_MAX, so it needs one extra bit.
  localparam int K_W            = 3;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_t;

  // Address plus small byte offset, wrapping naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_add(
    input logic [ADDR_W-1:0] base,
    input logic [K_W-1:0]    off
  );
    return base + {{(ADDR_W-K_W){1'b0}}, off};
  endfunction

endpackage

// File: rtl/tc_fetch_perf_ctr.sv
// Saturating stall and transfer counters for tc_insn_fetch8.
// Only instantiated when TC_INSN_FETCH_PERF_EN is defined.
module tc_fetch_perf_ctr
  import tc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        xfer,
  output logic [31:0] stall_cycles,
  output logic [31:0] insn_count
);

  logic [1:0] inc;
  assign inc = {xfer, stall};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ctr
    logic [31:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = g_ctr[0].cnt_reg;
  assign insn_count   = g_ctr[1].cnt_reg;

endmodule

// File: rtl/tc_insn_fetch8.sv
// Byte-serial instruction fetch: assembles INSN_BYTES bytes from an 8-bit program
// memory into one instruction. Optional perf counters under TC_INSN_FETCH_PERF_EN.
module tc_insn_fetch8
  import tc_fetch_pkg::*;
#(
  parameter int                INSN_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_data,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [INSN_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              insn_valid,
  input  logic              insn_ready
`ifdef TC_INSN_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       insn_count
`endif
);

  localparam logic [K_W-1:0] K_LAST = K_W'(INSN_BYTES);

  fetch_state_t      state_reg;
  logic [K_W-1:0]    k_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [INSN_W-1:0] asm_reg;
  logic [INSN_W-1:0] insn_reg;
  logic [ADDR_W-1:0] insn_pc_reg;
  logic              insn_valid_reg;

  logic [INSN_W-1:0] capture_word;
  logic [K_W-1:0]    fetch_off;
  logic              xfer;

  assign xfer = insn_valid_reg && insn_ready;

  // Byte k-1 is returned by memory while k is current; lanes beyond the
  // instruction length keep their reset value of zero.
  for (genvar gi = 0; gi < INSN_BYTES_MAX; gi++) begin : g_lane
    if (gi < INSN_BYTES) begin : g_used
      assign capture_word[gi*BYTE_W +: BYTE_W] =
        (k_reg == K_W'(gi + 1)) ? mem_data : asm_reg[gi*BYTE_W +: BYTE_W];
    end else begin : g_unused
      assign capture_word[gi*BYTE_W +: BYTE_W] = asm_reg[gi*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    fetch_off = (k_reg == K_LAST) ? '0 : k_reg;
    mem_addr  = addr_add(pc_reg, fetch_off);
    if (state_reg == ST_HOLD) begin
      mem_addr = insn_pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_FETCH;
      k_reg          <= '0;
      pc_reg         <= RESET_PC;
      asm_reg        <= '0;
      insn_reg       <= '0;
      insn_pc_reg    <= '0;
      insn_valid_reg <= 1'b0;
    end else if (jump_en) begin
      // Redirect wins over everything; a same-cycle transfer still counts
      // because xfer is evaluated from the current valid/ready.
      state_reg      <= ST_FETCH;
      k_reg          <= '0;
      pc_reg         <= jump_target;
      asm_reg        <= '0;
      insn_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (k_reg == K_LAST) begin
            insn_reg       <= capture_word;
            insn_pc_reg    <= pc_reg;
            insn_valid_reg <= 1'b1;
            asm_reg        <= '0;
            k_reg          <= '0;
            state_reg      <= ST_HOLD;
          end else begin
            if (k_reg != '0) begin
              asm_reg <= capture_word;
            end
            k_reg <= k_reg + K_W'(1);
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            pc_reg         <= addr_add(pc_reg, K_LAST);
            insn_valid_reg <= 1'b0;
            k_reg          <= '0;
            state_reg      <= ST_FETCH;
          end
        end
        default: begin
          state_reg <= ST_FETCH;
          k_reg     <= '0;
        end
      endcase
    end
  end

  assign insn       = insn_reg;
  assign insn_pc    = insn_pc_reg;
  assign insn_valid = insn_valid_reg;

`ifdef TC_INSN_FETCH_PERF_EN
  tc_fetch_perf_ctr u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall        (insn_valid_reg && !insn_ready),
    .xfer         (xfer),
    .stall_cycles (stall_cycles),
    .insn_count   (insn_count)
  );
`endif

endmodule

// File: tb/tb_tc_insn_fetch8.sv
// Directed bench: 4-byte instance for the main scenarios, 1-byte instance for
// short-instruction and reset-in-HOLD behaviour.
module tb_tc_insn_fetch8;

  logic        clk;
  logic        rst_a, rst_b;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic [7:0]  mem_data_a, mem_data_b;
  logic        jump_en_a, jump_en_b;
  logic [15:0] jump_target_a, jump_target_b;
  logic [31:0] insn_a, insn_b;
  logic [15:0] insn_pc_a, insn_pc_b;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b;
`ifdef TC_INSN_FETCH_PERF_EN
  logic [31:0] stall_a, count_a, stall_b, count_b;
`endif

  logic [7:0] mem [0:65535];
  int tests_run = 0;
  int tests_failed = 0;
  int n;

  tc_insn_fetch8 #(.INSN_BYTES(4), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .jump_en(jump_en_a), .jump_target(jump_target_a), .insn(insn_a),
    .insn_pc(insn_pc_a), .insn_valid(valid_a), .insn_ready(ready_a)
`ifdef TC_INSN_FETCH_PERF_EN
    , .stall_cycles(stall_a), .insn_count(count_a)
`endif
  );

  tc_insn_fetch8 #(.INSN_BYTES(1), .RESET_PC(16'h0010)) dut_b (
    .clk(clk), .rst(rst_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .jump_en(jump_en_b), .jump_target(jump_target_b), .insn(insn_b),
    .insn_pc(insn_pc_b), .insn_valid(valid_b), .insn_ready(ready_b)
`ifdef TC_INSN_FETCH_PERF_EN
    , .stall_cycles(stall_b), .insn_count(count_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered program memory: data appears one cycle after the address.
  always @(posedge clk) begin
    mem_data_a <= mem[mem_addr_a];
    mem_data_b <= mem[mem_addr_b];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until the selected valid rises, bounded at 40 cycles.
  task automatic wait_valid(input bit sel_b, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(sel_b ? valid_b : valid_a) && cycles < 40);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22; mem[16'h0002] = 8'h33; mem[16'h0003] = 8'h44;
    mem[16'h0004] = 8'h55; mem[16'h0005] = 8'h66; mem[16'h0006] = 8'h77; mem[16'h0007] = 8'h88;
    mem[16'h0010] = 8'h5A; mem[16'h0011] = 8'h6B;
    mem[16'h0100] = 8'hA1; mem[16'h0101] = 8'hB2; mem[16'h0102] = 8'hC3; mem[16'h0103] = 8'hD4;
    mem[16'hFFFE] = 8'hE1; mem[16'hFFFF] = 8'hF2;

    rst_a = 1'b0; rst_b = 1'b0;
    jump_en_a = 1'b0; jump_target_a = 16'h0000; ready_a = 1'b0;
    jump_en_b = 1'b0; jump_target_b = 16'h0000; ready_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", {63'd0, valid_a}, 64'd0);
    check("rst_insn", {32'd0, insn_a}, 64'd0);
    check("rst_insn_pc", {48'd0, insn_pc_a}, 64'd0);
    check("rst_mem_addr", {48'd0, mem_addr_a}, 64'd0);
`ifdef TC_INSN_FETCH_PERF_EN
    check("rst_stall", {32'd0, stall_a}, 64'd0);
    check("rst_count", {32'd0, count_a}, 64'd0);
`endif

    // First fetch after reset release, consumer ready
    ready_a = 1'b1;
    rst_a = 1'b1;
    check("rel_mem_addr", {48'd0, mem_addr_a}, 64'h0000);
    wait_valid(1'b0, n);
    check("first_latency", 64'(n), 64'd5);
    check("first_insn", {32'd0, insn_a}, 64'h44332211);
    check("first_insn_pc", {48'd0, insn_pc_a}, 64'h0000);
    check("hold_mem_addr", {48'd0, mem_addr_a}, 64'h0000);

    // Transfer, then second instruction with consumer stalled
    @(negedge clk);
    ready_a = 1'b0;
    check("xfer_valid_clr", {63'd0, valid_a}, 64'd0);
    check("next_fetch_addr", {48'd0, mem_addr_a}, 64'h0004);
    wait_valid(1'b0, n);
    check("second_latency", 64'(n), 64'd5);
    check("second_insn_pc", {48'd0, insn_pc_a}, 64'h0004);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_hold_%0d", i),
            {15'd0, valid_a, insn_a, insn_pc_a},
            {15'd0, 1'b1, 32'h88776655, 16'h0004});
      @(negedge clk);
    end
    check("stall_end_insn", {32'd0, insn_a}, 64'h88776655);
`ifdef TC_INSN_FETCH_PERF_EN
    check("stall_cycles", {32'd0, stall_a}, 64'd10);
    check("count_after_1", {32'd0, count_a}, 64'd1);
`endif

    // Jump together with a transfer, into an address-wrapping fetch
    ready_a = 1'b1;
    jump_en_a = 1'b1;
    jump_target_a = 16'hFFFE;
    @(negedge clk);
    jump_en_a = 1'b0;
    check("jx_valid_clr", {63'd0, valid_a}, 64'd0);
    check("jx_mem_addr", {48'd0, mem_addr_a}, 64'hFFFE);
`ifdef TC_INSN_FETCH_PERF_EN
    check("jx_count", {32'd0, count_a}, 64'd2);
    check("jx_stall", {32'd0, stall_a}, 64'd10);
`endif
    wait_valid(1'b0, n);
    check("wrap_latency", 64'(n), 64'd5);
    check("wrap_insn", {32'd0, insn_a}, 64'h2211F2E1);
    check("wrap_insn_pc", {48'd0, insn_pc_a}, 64'hFFFE);

    // Transfer from the wrapped instruction, then jump at k=2
    @(negedge clk);
    check("wrap_next_pc", {48'd0, mem_addr_a}, 64'h0002);
`ifdef TC_INSN_FETCH_PERF_EN
    check("wrap_count", {32'd0, count_a}, 64'd3);
`endif
    repeat (2) @(negedge clk);
    check("k2_mem_addr", {48'd0, mem_addr_a}, 64'h0004);
    jump_en_a = 1'b1;
    jump_target_a = 16'h0100;
    @(negedge clk);
    jump_en_a = 1'b0;
    check("jmp_valid", {63'd0, valid_a}, 64'd0);
    check("jmp_mem_addr", {48'd0, mem_addr_a}, 64'h0100);
    wait_valid(1'b0, n);
    check("jmp_latency", 64'(n), 64'd5);
    check("jmp_insn", {32'd0, insn_a}, 64'hD4C3B2A1);
    check("jmp_insn_pc", {48'd0, insn_pc_a}, 64'h0100);
    ready_a = 1'b0;

    // One-byte instance: short latency, zero upper bytes, reset in HOLD
    check("b_held_rst_valid", {63'd0, valid_b}, 64'd0);
    rst_b = 1'b1;
    check("b_rel_mem_addr", {48'd0, mem_addr_b}, 64'h0010);
    wait_valid(1'b1, n);
    check("b_latency", 64'(n), 64'd2);
    check("b_insn", {32'd0, insn_b}, 64'h0000005A);
    check("b_upper_zero", {40'd0, insn_b[31:8]}, 64'd0);
    check("b_insn_pc", {48'd0, insn_pc_b}, 64'h0010);
    @(negedge clk);
    check("b_hold_stable", {15'd0, valid_b, insn_b, insn_pc_b},
          {15'd0, 1'b1, 32'h0000005A, 16'h0010});
    rst_b = 1'b0;
    #1;
    check("b_async_valid", {63'd0, valid_b}, 64'd0);
    check("b_async_insn", {32'd0, insn_b}, 64'd0);
    check("b_async_insn_pc", {48'd0, insn_pc_b}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    ready_b = 1'b1;
    check("b_restart_addr", {48'd0, mem_addr_b}, 64'h0010);
    check("b_restart_valid", {63'd0, valid_b}, 64'd0);
    wait_valid(1'b1, n);
    check("b_re_latency", 64'(n), 64'd2);
    check("b_re_insn", {32'd0, insn_b}, 64'h0000005A);
    @(negedge clk);
    check("b_next_addr", {48'd0, mem_addr_b}, 64'h0011);
    wait_valid(1'b1, n);
    check("b_next_latency", 64'(n), 64'd2);
    check("b_next_insn", {32'd0, insn_b}, 64'h0000006B);
    check("b_next_insn_pc", {48'd0, insn_pc_b}, 64'h0011);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
